serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal range 2 to 64.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-006 a  input  WIDTH  augend; sampled on the cycle start is accepted.
REQ-007 b  input  WIDTH  addend; sampled on the cycle start is accepted.
REQ-008 cin  input  1  carry-in; sampled on the cycle start is accepted.
REQ-009 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 sum  output  WIDTH  registered result, a + b + cin mod 2^WIDTH.
REQ-012 cout  output  1  registered carry out of bit WIDTH-1.
REQ-013 overflow  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL load a, b and cin into internal shift registers and a carry flop. It SHALL also clear the bit counter and enter RUN at the same edge.
REQ-016 Each RUN cycle SHALL perform one full-add on the operand LSBs and the carry flop.
  - sum bit = a0 ^ b0 ^ c
  - next carry = a0&b0 | a0&c | b0&c
REQ-017 Each RUN cycle SHALL shift the sum bit into the partial-sum register MSB-first, shift both operands right by one, and increment the counter.
REQ-018 Carry SHALL ripple through the carry flop only; the datapath SHALL hold exactly one full-add cell and no WIDTH-bit adder.
REQ-019 The block SHALL capture the carry into the MSB (the carry-flop value before the final add) for the overflow calculation.
REQ-020 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE at the same edge that updates sum, cout and overflow from the completed partial sum and carries.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-022 Latency: if start is accepted at edge k, done SHALL be high in the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-023 The next start SHALL be accepted no earlier than edge k+WIDTH+1.
REQ-024 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-025 start asserted while busy=1 SHALL be ignored with no effect on state, operands or outputs.
REQ-026 A start held high continuously SHALL begin a new operation at each return to IDLE, giving back-to-back operations every WIDTH+1 cycles.
REQ-027 sum, cout and overflow SHALL hold their last values until the next DONE entry and SHALL NOT show partial results during RUN.
REQ-028 Changes on a, b or cin after acceptance SHALL NOT affect the operation in progress.
REQ-029 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-030 rst_n=0 SHALL immediately force the following, regardless of clk:
  - state to IDLE
  - busy, done, cout and overflow to 0
  - sum to all-zeros
  - shift registers, carry flop and counter to 0
REQ-031 Reset asserted mid-RUN or mid-DONE SHALL abort the operation without producing a done pulse.
REQ-032 The first start after rst_n deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-033 a=0x5A, b=0x33, cin=0, start pulse -> done 8 cycles after acceptance edge; sum=0x8D, cout=0, overflow=1.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, overflow=0.
REQ-035 a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, overflow=1; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
REQ-036 Start accepted with a=0x10, b=0x20; at RUN cycle 3, assert start with a=0xFF, b=0xFF -> second request ignored; result sum=0x30; busy stays high throughout.
REQ-037 rst_n pulsed low during RUN cycle 4 -> all outputs 0 immediately; no done pulse; a following start with a=0x01, b=0x02 gives sum=0x03.
REQ-038 start held high for 3 operations, with operands changed only at acceptance edges -> done pulses exactly 9 cycles apart, each with the correct sum.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and result bus of the bit-serial adder.
// The master side requests additions; the slave side is the adder itself.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell and a carry flop.
// Each operand bit takes one cycle; results are registered on entry to DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_carry;

    always_comb begin
        fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
        fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            psum         <= '0;
            carry        <= 1'b0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.sum      <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr     <= bus.a;
                        b_sr     <= bus.b;
                        carry    <= bus.cin;
                        psum     <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    psum  <= {fa_sum, psum[WIDTH-1:1]};
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= fa_carry;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here
                        bus.sum      <= {fa_sum, psum[WIDTH-1:1]};
                        bus.cout     <= fa_carry;
                        bus.overflow <= carry ^ fa_carry;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    // The return to IDLE and a pending start share this edge,
                    // giving one operation every WIDTH+1 cycles.
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        psum  <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed table, corner
// sequences and random operations against an arithmetic reference.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] s, output logic co, output logic ov);
        logic [W-1:0] prev_sum;
        logic         held;
        int           lat;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        prev_sum  = bus.sum;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        held      = 1'b1;
        lat       = 0;
        for (int n = 1; n <= W + 3 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) lat = n;
            else if (bus.sum !== prev_sum) held = 1'b0;
        end
        check("sum_held_during_run", 64'(held), 64'd1);
        check("done_latency", 64'(lat), 64'(W));
        s  = bus.sum;
        co = bus.cout;
        ov = bus.overflow;
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] s;
        logic         co, ov;
        logic [W+1:0] r;
        logic [W-1:0] opa[3];
        logic [W-1:0] opb[3];
        logic         opc[3];
        int           done_at[3];
        int           ndone, lat, done_cnt;
        logic         busy_ok, prev_done;

        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_sum", 64'(bus.sum), 64'd0);
        check("reset_cout", 64'(bus.cout), 64'd0);
        check("reset_ovf", 64'(bus.overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov);
            check($sformatf("tbl%0d_sum", i), 64'(s), 64'(tbl[i].sum));
            check($sformatf("tbl%0d_cout", i), 64'(co), 64'(tbl[i].cout));
            check($sformatf("tbl%0d_ovf", i), 64'(ov), 64'(tbl[i].ovf));
        end

        // start re-asserted with new operands during RUN cycle 3 is ignored
        @(negedge clk);
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_ok = 1'b1;
        lat = 0;
        for (int n = 1; n <= W + 3 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; end
            if (n == 3) bus.start = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) lat = n;
        end
        check("ignore_busy_high", 64'(busy_ok), 64'd1);
        check("ignore_latency", 64'(lat), 64'(W));
        check("ignore_sum", 64'(bus.sum), 64'h30);
        @(posedge clk);
        #1;
        check("ignore_back_idle", 64'(bus.busy), 64'd0);

        // asynchronous reset during RUN cycle 4 aborts without a done pulse
        @(negedge clk);
        bus.a = 8'h33; bus.b = 8'h44; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_sum", 64'(bus.sum), 64'd0);
        check("abort_cout", 64'(bus.cout), 64'd0);
        check("abort_ovf", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < W + 3; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        run_op(8'h01, 8'h02, 1'b0, s, co, ov);
        check("after_abort_sum", 64'(s), 64'h03);

        // start held high: three back-to-back operations
        for (int i = 0; i < 3; i++) begin
            opa[i] = W'($urandom); opb[i] = W'($urandom); opc[i] = 1'($urandom);
            done_at[i] = 0;
        end
        @(negedge clk);
        bus.a = opa[0]; bus.b = opb[0]; bus.cin = opc[0]; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = opa[1]; bus.b = opb[1]; bus.cin = opc[1];
        ndone = 0;
        prev_done = 1'b0;
        for (int n = 1; n <= 40 && ndone < 3; n++) begin
            @(posedge clk);
            #1;
            if (prev_done && ndone + 1 < 3) begin
                bus.a = opa[ndone + 1]; bus.b = opb[ndone + 1]; bus.cin = opc[ndone + 1];
            end
            prev_done = bus.done;
            if (bus.done) begin
                r = ref_add(opa[ndone], opb[ndone], opc[ndone]);
                check($sformatf("b2b%0d_sum", ndone), 64'(bus.sum), 64'(r[W-1:0]));
                check($sformatf("b2b%0d_cout", ndone), 64'(bus.cout), 64'(r[W]));
                check($sformatf("b2b%0d_ovf", ndone), 64'(bus.overflow), 64'(r[W+1]));
                done_at[ndone] = n;
                ndone++;
                if (ndone == 3) bus.start = 1'b0;
            end
        end
        check("b2b_count", 64'(ndone), 64'd3);
        check("b2b_first_latency", 64'(done_at[0]), 64'(W));
        check("b2b_gap1", 64'(done_at[1] - done_at[0]), 64'(W + 1));
        check("b2b_gap2", 64'(done_at[2] - done_at[1]), 64'(W + 1));
        @(posedge clk);
        #1;
        check("b2b_back_idle", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i == 0) begin ra = '0; rb = '0; rc = 1'b0; end
            r = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, s, co, ov);
            check($sformatf("rnd%0d_sum", i), 64'(s), 64'(r[W-1:0]));
            check($sformatf("rnd%0d_cout", i), 64'(co), 64'(r[W]));
            check($sformatf("rnd%0d_ovf", i), 64'(ov), 64'(r[W+1]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
